// File: rtl/ov7670_frame_capture.sv
// OV7670 parallel-bus capture: assembles pixels (luma / RGB565 / raw), optional 2x2 decimation,
// and emits linear frame-buffer writes with frame, line-length and overflow status.
module ov7670_frame_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    input  logic              cap_en,
    input  logic [1:0]        mode,
    input  logic              dec,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              line_err,
    output logic              ovf,
    output logic [7:0]        frame_cnt
);

    // Counter widths leave headroom so an over-long line still differs from H_ACTIVE.
    localparam int unsigned X_W = $clog2(H_ACTIVE + 2);
    localparam int unsigned Y_W = $clog2(V_ACTIVE + 2);
    localparam int unsigned P_W = ADDR_W + 1;
    localparam logic [P_W-1:0] CAP_FULL = P_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [P_W-1:0] CAP_DEC  = P_W'((H_ACTIVE / 2) * (V_ACTIVE / 2));
    localparam logic [X_W-1:0] X_EXP    = X_W'(H_ACTIVE);

    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic              en_q, en_d;
    logic [1:0]        mode_q, mode_d;
    logic              dec_q, dec_d;
    logic              phase_q, phase_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [P_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              pix_done;
    logic [15:0]       pix_data;
    logic [P_W-1:0]    cap;

    // Next-state: vsync has priority over href; pixel assembly, write qualification, line end.
    always_comb begin
        vsync_d      = vsync;
        href_d       = href;
        en_d         = en_q;
        mode_d       = mode_q;
        dec_d        = dec_q;
        phase_d      = phase_q;
        byte0_d      = byte0_q;
        x_d          = x_q;
        y_d          = y_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        line_err_d   = 1'b0;
        ovf_d        = ovf_q;
        frame_cnt_d  = frame_cnt_q;
        pix_done     = 1'b0;
        pix_data     = '0;
        cap          = dec_q ? CAP_DEC : CAP_FULL;

        if (vsync) begin
            en_d    = cap_en;
            mode_d  = (mode == 2'd3) ? 2'd0 : mode;
            dec_d   = dec;
            phase_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
            ptr_d   = '0;
            ovf_d   = 1'b0;
            if (!vsync_q && ((x_q != '0) || (y_q != '0))) begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
            end
        end else if (href) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                byte0_d = din;
            end
            if (mode_q == 2'd2) begin
                pix_done = 1'b1;
                pix_data = {8'h00, din};
            end else if (phase_q) begin
                pix_done = 1'b1;
                pix_data = (mode_q == 2'd1) ? {byte0_q, din} : {8'h00, byte0_q};
            end
            if (pix_done) begin
                if (x_q != {X_W{1'b1}}) begin
                    x_d = x_q + X_W'(1);
                end
                if (en_q && (!dec_q || (!x_q[0] && !y_q[0]))) begin
                    if (ptr_q < cap) begin
                        we_d   = 1'b1;
                        addr_d = ptr_q[ADDR_W-1:0];
                        dout_d = pix_data;
                        ptr_d  = ptr_q + P_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end else begin
            phase_d = 1'b0;
            if (href_q && (x_q != '0)) begin
                x_d        = '0;
                line_err_d = (x_q != X_EXP);
                if (y_q != {Y_W{1'b1}}) begin
                    y_d = y_q + Y_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            en_q         <= 1'b0;
            mode_q       <= 2'd0;
            dec_q        <= 1'b0;
            phase_q      <= 1'b0;
            byte0_q      <= 8'h00;
            x_q          <= '0;
            y_q          <= '0;
            ptr_q        <= '0;
            addr_q       <= '0;
            dout_q       <= 16'h0000;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            ovf_q        <= 1'b0;
            frame_cnt_q  <= 8'h00;
        end else begin
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            en_q         <= en_d;
            mode_q       <= mode_d;
            dec_q        <= dec_d;
            phase_q      <= phase_d;
            byte0_q      <= byte0_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            ovf_q        <= ovf_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign ovf        = ovf_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/ov7670_frame_capture.md
# ov7670_frame_capture

Parametrised camera capture stage between the OV7670 parallel byte bus and the frame-buffer write port. Assembles pixels in one of three runtime-selectable byte formats, with optional 2x2 decimation, and issues single-cycle writes with a linear address. Also reports frame completion, line-length errors and buffer overflow. Capture enable, format and decimation are sampled only while vsync is high, so configuration never changes mid-frame.

## Interface
Parameters:
- H_ACTIVE, 640: expected pixels per line (sensor output, before decimation).
- V_ACTIVE, 480: expected lines per frame.
- ADDR_W, 19: write address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- pclk  in  1  sensor pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vsync  in  1  frame sync, high = vertical blank.
- href  in  1  line valid, high = active bytes on din.
- din  in  8  sensor data byte.
- cap_en  in  1  capture enable, sampled during vsync.
- mode  in  2  0 = YUV422 luma only, 1 = RGB565, 2 = raw byte-per-pixel, 3 = reserved (treated as 0).
- dec  in  1  1 = 2x2 decimation, sampled during vsync.
- addr  out  ADDR_W  write address, valid when we=1.
- dout  out  16  write data.
- we  out  1  write strobe, one cycle per pixel.
- frame_done  out  1  one-cycle pulse at end of frame.
- line_err  out  1  one-cycle pulse on a line of wrong length.
- ovf  out  1  sticky overflow flag, cleared at vsync.
- frame_cnt  out  8  completed-frame counter.

## Operation
- Reset: all outputs 0; shadow cap_en, mode and dec = 0, so there are no writes until the first vsync.
- While vsync=1, every cycle:
  - load shadows from cap_en, mode and dec;
  - clear byte phase, x, y, the write pointer and ovf.
- vsync priority: vsync=1 overrides href; a partially assembled pixel is discarded.
- Byte phase toggles on each cycle with href=1 and clears when href=0.
- Pixel complete:
  - mode 0: on phase 1. dout = {8'h00, phase-0 byte}; the chroma byte is dropped.
  - mode 1: on phase 1. dout = {phase-0 byte, phase-1 byte}.
  - mode 2: on every href byte. dout = {8'h00, din}.
- x counts completed pixels in the line and saturates at all-ones.
- Line end is an href 1->0 transition with x>0. On line end:
  - y increments, saturating;
  - x clears;
  - line_err pulses if x != H_ACTIVE.
- Write qualified by all of:
  - pixel complete;
  - shadow cap_en=1;
  - if dec=1, x[0]=0 and y[0]=0;
  - write pointer < capacity. Capacity = H_ACTIVE*V_ACTIVE, or (H_ACTIVE/2)*(V_ACTIVE/2) when dec=1.
- A qualified pixel at or beyond capacity is not written and sets ovf until the next vsync.
- Each write increments the write pointer; the pointer never wraps within a frame.
- Frame end is a vsync 0->1 transition with y>0 or x>0. On frame end:
  - frame_done pulses;
  - frame_cnt increments, wrapping 255->0.
  - Both happen regardless of cap_en.
- dout and addr hold their last values when we=0.

## Timing
- Output registers: addr, dout, we, line_err and frame_done are all registered.
- Write latency: the byte completing a pixel, sampled at edge N, gives we=1 with its dout and addr during cycle N+1.
- Write rate: mode 0/1 at most one write per 2 pclk; mode 2 at most one per pclk. There is no backpressure: the consumer must accept every we.
- line_err: asserted the cycle after href is sampled 0 at line end.
- frame_done: asserted the cycle after vsync is first sampled 1.
- frame_cnt: updates in the same cycle frame_done is asserted.
- Odd-length href bursts in mode 0/1: the trailing single byte is discarded, not counted in x, and no write is issued.
- Config changes outside vsync take effect at the next vsync.
- Asserting rst_n mid-frame returns to the reset state. Because the shadows reset to 0, capture resumes only after the next vsync.

## Test plan
- **Reset and frame-synced enable:** reset, then cap_en=1 with no vsync, drive 4 lines of 640 mode-1 pixels -> no we.
- **Full RGB565 frame:** vsync pulse, then a 640x480 frame -> 307200 writes at addr 0..307199, dout = {b0,b1} per pixel, frame_done once, frame_cnt=1.
- **Luma-only with decimation:** mode 0, dec=1, 640x480 frame with Y = x[7:0] -> 76800 writes, dout = 16'h0000, 0x0002, 0x0004, …, last addr 76799.
- **Short line and odd burst:** a line of 639 pixels -> line_err pulse one cycle after href falls, y still advances. A 3-byte href burst in mode 1 -> exactly one write.
- **Overflow:** mode 2, dec=0, 640x481 lines of 640 bytes -> writes stop after addr 307199, ovf=1 until next vsync, then clears.
- **Vsync interrupt:** vsync asserted mid-line and mid-pixel -> no write for the partial pixel, next frame starts at addr 0. 256 frames -> frame_cnt wraps to 0.
